// File: rtl/axi_burst_writer_pkg.sv
// Shared AXI codes, FSM state encodings and the 4KB boundary helper for axi_burst_writer.
package axi_burst_writer_pkg;

  localparam logic [1:0] AXI_BURST_TYPE_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B         = 3'b010;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ADDR = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_RESP = 3'd3;
  localparam logic [2:0] ST_FIN  = 3'd4;

  // True when a burst of (len+1) 4-byte beats starting at addr_lo runs past the 4KB page.
  function automatic logic crosses_4k(input logic [11:0] addr_lo, input logic [7:0] len);
    logic [12:0] end_b;
    end_b = {1'b0, addr_lo[11:2], 2'b00} + {2'b00, ({1'b0, len} + 9'd1), 2'b00};
    return end_b > 13'd4096;
  endfunction

endpackage

// File: rtl/axi_burst_writer_if.sv
// AXI4 write-channel bundle (AW, W, B) with master/slave views.
interface axi_burst_writer_if #(
  parameter int ADDR_W = 32
);
  logic [3:0]        awid;
  logic [ADDR_W-1:0] awadr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic              awvalid;
  logic              awready;
  logic [31:0]       wrdata;
  logic [3:0]        wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;
  logic [3:0]        bid;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  modport master (
    output awid, awadr, awlen, awsize, awburst, awvalid,
    output wrdata, wstrb, wlast, wvalid,
    output bready,
    input  awready, wready, bid, bresp, bvalid
  );

  modport slave (
    input  awid, awadr, awlen, awsize, awburst, awvalid,
    input  wrdata, wstrb, wlast, wvalid,
    input  bready,
    output awready, wready, bid, bresp, bvalid
  );
endinterface

// File: rtl/axi_burst_writer_wbeat_reg.sv
// Single-entry W output register: holds data/wlast stable until the slave takes the beat.
module axi_wbeat_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        load,
  input  logic [31:0] load_data,
  input  logic        load_last,
  input  logic        wready,
  output logic        wvalid,
  output logic [31:0] wdata,
  output logic        wlast
);
  logic        wvalid_q, wvalid_d;
  logic [31:0] wdata_q, wdata_d;
  logic        wlast_q, wlast_d;

  always_comb begin
    wvalid_d = wvalid_q;
    wdata_d  = wdata_q;
    wlast_d  = wlast_q;
    if (load) begin
      wvalid_d = 1'b1;
      wdata_d  = load_data;
      wlast_d  = load_last;
    end else if (wvalid_q && wready) begin
      wvalid_d = 1'b0;
      wlast_d  = 1'b0;
    end
    if (clr) begin
      wvalid_d = 1'b0;
      wlast_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wvalid_q <= 1'b0;
      wdata_q  <= '0;
      wlast_q  <= 1'b0;
    end else begin
      wvalid_q <= wvalid_d;
      wdata_q  <= wdata_d;
      wlast_q  <= wlast_d;
    end
  end

  assign wvalid = wvalid_q;
  assign wdata  = wdata_q;
  assign wlast  = wlast_q;
endmodule

// File: rtl/axi_burst_writer.sv
// Single INCR-burst AXI4 write initiator: command in, streamed beats out, B response reported.
// Optional watchdog enabled by defining AXI_WR_TIMEOUT_EN.
module axi_burst_writer
  import axi_burst_writer_pkg::*;
#(
  parameter int         ADDR_W      = 32,
  parameter logic [3:0] AXI_ID      = 4'h0,
  parameter int         TIMEOUT_CYC = 1024
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [7:0]        cmd_len,
  input  logic [31:0]       src_data,
  input  logic              src_valid,
  output logic              src_ready,
  output logic              done,
  output logic [1:0]        done_resp,
  axi_burst_writer_if.master axi
);
  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        len_q, len_d;
  logic [8:0]        loaded_q, loaded_d;
  logic [1:0]        resp_q, resp_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              awvalid_q, awvalid_d;
  logic              bready_q, bready_d;
  logic              done_q, done_d;
  logic              load, load_last, wclr;
  logic              wvalid, wlast;
  logic [31:0]       wdata;
  logic              tmo_hit;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    loaded_d  = loaded_q;
    resp_d    = resp_q;
    wclr      = 1'b0;
    // Taking a beat in the AW handshake cycle lets the first W beat follow the address immediately.
    src_ready = (state_q == ST_DATA || (state_q == ST_ADDR && axi.awready)) &&
                (loaded_q <= {1'b0, len_q}) && (!wvalid || axi.wready);
    load      = src_ready && src_valid;
    load_last = (loaded_q == {1'b0, len_q});
    if (load) loaded_d = loaded_q + 9'd1;

    case (state_q)
      ST_IDLE: if (cmd_valid && cmd_ready_q) begin
        addr_d   = cmd_addr & ~ADDR_W'(3);
        len_d    = cmd_len;
        loaded_d = '0;
        if (crosses_4k(cmd_addr[11:0], cmd_len)) begin
          state_d = ST_FIN;
          resp_d  = RESP_SLVERR;
        end else begin
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: if (axi.awready) state_d = ST_DATA;
      ST_DATA: if (wvalid && axi.wready && wlast) state_d = ST_RESP;
      ST_RESP: if (axi.bvalid) begin
        resp_d  = (axi.bid != AXI_ID) ? RESP_SLVERR : axi.bresp;
        state_d = ST_FIN;
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (tmo_hit) begin
      state_d   = ST_FIN;
      resp_d    = RESP_DECERR;
      wclr      = 1'b1;
      src_ready = 1'b0;
      load      = 1'b0;
      loaded_d  = loaded_q;
    end

    cmd_ready_d = (state_d == ST_IDLE);
    awvalid_d   = (state_d == ST_ADDR);
    bready_d    = (state_d == ST_RESP);
    done_d      = (state_d == ST_FIN);
  end

`ifdef AXI_WR_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          any_hs;

  always_comb begin
    any_hs = (awvalid_q && axi.awready) || (wvalid && axi.wready) ||
             (bready_q && axi.bvalid) || load;
    tmo_d  = (state_d != state_q || any_hs) ? '0 : tmo_q + 1'b1;
  end

  assign tmo_hit = (tmo_q == TW'(TIMEOUT_CYC - 1)) &&
                   (state_q == ST_ADDR || state_q == ST_DATA || state_q == ST_RESP);

  always_ff @(posedge aclk) begin
    if (areset) tmo_q <= '0;
    else        tmo_q <= tmo_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      loaded_q    <= '0;
      resp_q      <= '0;
      cmd_ready_q <= 1'b0;
      awvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      loaded_q    <= loaded_d;
      resp_q      <= resp_d;
      cmd_ready_q <= cmd_ready_d;
      awvalid_q   <= awvalid_d;
      bready_q    <= bready_d;
      done_q      <= done_d;
    end
  end

  axi_wbeat_reg u_wbeat (
    .clk       (aclk),
    .rst       (areset),
    .clr       (wclr),
    .load      (load),
    .load_data (src_data),
    .load_last (load_last),
    .wready    (axi.wready),
    .wvalid    (wvalid),
    .wdata     (wdata),
    .wlast     (wlast)
  );

  assign cmd_ready   = cmd_ready_q;
  assign done        = done_q;
  assign done_resp   = resp_q;
  assign axi.awid    = AXI_ID;
  assign axi.awadr   = addr_q;
  assign axi.awlen   = len_q;
  assign axi.awsize  = AXI_SIZE_4B;
  assign axi.awburst = AXI_BURST_TYPE_INCR;
  assign axi.awvalid = awvalid_q;
  assign axi.wrdata  = wdata;
  assign axi.wstrb   = '1;
  assign axi.wlast   = wlast;
  assign axi.wvalid  = wvalid;
  assign axi.bready  = bready_q;
endmodule
